dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h6600_0000, byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-003 The block SHALL have parameter RD_LAT, default 1, cycles from request acceptance to response (legal 1..4).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk_i, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port req_i, input, 1, access request.
REQ-008 The block SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-009 The block SHALL have port size_i, input, 3, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 The block SHALL have port addr_i, input, 32, byte address.
REQ-011 The block SHALL have port wd_i, input, 32, store data, right-aligned.
REQ-012 The block SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-013 The block SHALL have port rvalid_o, output, 1, one-cycle response strobe.
REQ-014 The block SHALL have port rd_o, output, 32, load result, valid with rvalid_o.
REQ-015 The block SHALL have port err_o, output, 1, access error, valid with rvalid_o.
REQ-016 The block SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; gnt_o = req_i AND state==IDLE (combinational).
REQ-018 On acceptance, addr_i/size_i/we_i/wd_i SHALL be registered; IDLE->RESP when RD_LAT=1, else IDLE->WAIT.
REQ-019 WAIT SHALL hold for RD_LAT-1 cycles via down-counter, then ->RESP; RESP->IDLE unconditionally.
REQ-020 rvalid_o SHALL be high for exactly one cycle, RD_LAT cycles after the acceptance cycle; req_i outside IDLE is ignored (not granted).
REQ-021 A store SHALL commit on the clock edge ending the acceptance cycle; its response has rd_o=0, err_o=0.
REQ-022 Store lanes: SB writes byte addr[1:0] from wd_i[7:0]; SH writes half addr[1] from wd_i[15:0]; SW writes all four bytes; other lanes unchanged.
REQ-023 Load data SHALL be read from the word at the acceptance edge; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-024 Error SHALL be flagged when addr < BASE_ADDR, or addr-BASE_ADDR >= 4*DEPTH_WORDS, or H/HU with addr[0]=1, or W with addr[1:0]!=0, or size in {011,110,111}, or BU/HU with we_i=1.
REQ-025 Errored accesses SHALL write nothing, return rd_o=0, err_o=1, with the same latency as legal accesses.
REQ-026 Word index SHALL be (addr-BASE_ADDR)>>2 truncated to log2(DEPTH_WORDS) bits, used only after the range check.
REQ-027 rd_o and err_o SHALL be 0 whenever rvalid_o=0.

Reset
REQ-028 rst_i SHALL force state IDLE, counter 0, gnt_o/rvalid_o/err_o/busy_o=0, rd_o=0 from the next edge.
REQ-029 Reset mid-operation SHALL abort the pending response (no rvalid_o); a store already committed SHALL remain in memory.
REQ-030 Memory contents SHALL NOT be affected by reset; simulation initial contents are zero.

Structure
REQ-031 Shared package dm_pkg SHALL hold size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the FSM state type.
REQ-032 Storage SHALL be sub-module dm_ram: single-port, DEPTH_WORDS x 32, 4-bit byte-enable write, synchronous read.

Verification
REQ-033 RD_LAT=1: SW 0x6600_0004 <- 0xFBFB_BFFF, then LW 0x6600_0004 -> rvalid one cycle after gnt, rd_o=0xFBFB_BFFF, err_o=0.
REQ-034 Following REQ-033: LB 0x6600_0007 -> 0xFFFF_FFFB; LBU 0x6600_0007 -> 0x0000_00FB; SH 0x6600_0006 <- 0x1234 then LW 0x6600_0004 -> 0x1234_BFFF.
REQ-035 LW 0x6600_0003 -> err_o=1, rd_o=0; SW 0x6600_1000 with DEPTH_WORDS=1024 -> err_o=1, memory word 0 and word 1023 unchanged.
REQ-036 RD_LAT=3: req_i held high continuously -> gnt_o every 4th cycle, rvalid_o exactly 3 cycles after each gnt, busy_o high between.
REQ-037 RD_LAT=3: assert rst_i for one cycle during WAIT after SW 0x6600_0010 <- 0x9 -> no rvalid_o; subsequent LW 0x6600_0010 -> 0x0000_0009.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: access size codes,
// FSM state type and the load-result alignment/extension helper.
package dm_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   // Pick the addressed byte/half out of the word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [2:0]  size,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
      logic [31:0] byte_sh;
      logic [31:0] half_sh;
      logic [31:0] res;
      byte_sh = word >> {lo, 3'b000};
      half_sh = word >> {lo[1], 4'b0000};
      case (size)
         SZ_B:    res = {{24{byte_sh[7]}}, byte_sh[7:0]};
         SZ_BU:   res = {24'h0, byte_sh[7:0]};
         SZ_H:    res = {{16{half_sh[15]}}, half_sh[15:0]};
         SZ_HU:   res = {16'h0, half_sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a
// registered (read-first) read port.
module dm_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wd_i,
   output logic [31:0]   rd_o
);

   // One byte-wide array per lane keeps each lane a single-writer memory.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_q [DEPTH_WORDS];
         logic [7:0] rd_q;

         always_ff @(posedge clk_i) begin
            if (en_i) begin
               rd_q <= mem_q[addr_i];
               if (be_i[gi]) begin
                  mem_q[addr_i] <= wd_i[8*gi +: 8];
               end
            end
         end

         assign rd_o[8*gi +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-enabled data RAM: validates each access,
// commits stores at acceptance and returns a response RD_LAT cycles later.
module dmem_lsu
   import dm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h6600_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LAT      = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wd_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rd_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  lo_q;
   logic [2:0]  size_q;
   logic        we_q;
   logic        err_q;

   logic        accept;
   logic        req_err;
   logic        size_bad;
   logic        align_bad;
   logic [32:0] off;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] ram_rd;

   // 33-bit offset: an address below BASE_ADDR wraps to a huge value and fails the span test.
   assign off       = {1'b0, addr_i} - {1'b0, BASE_ADDR};
   assign align_bad = (((size_i == SZ_H) || (size_i == SZ_HU)) && addr_i[0])
                   || ((size_i == SZ_W) && (addr_i[1:0] != 2'b00));
   assign req_err   = (off >= SPAN) || size_bad || align_bad;
   assign accept    = req_i && (state_q == IDLE) && !rst_i;
   assign gnt_o     = accept;

   always_comb begin
      size_bad = 1'b0;
      be       = 4'b0000;
      wdata    = wd_i;
      case (size_i)
         SZ_B: begin
            be    = 4'b0001 << addr_i[1:0];
            wdata = {4{wd_i[7:0]}};
         end
         SZ_H: begin
            be    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wd_i[15:0]}};
         end
         SZ_W:    be       = 4'b1111;
         SZ_BU,
         SZ_HU:   size_bad = we_i;
         default: size_bad = 1'b1;
      endcase
   end

   dm_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk_i  (clk_i),
      .en_i   (accept && !req_err),
      .be_i   (we_i ? be : 4'b0000),
      .addr_i (off[AW+1:2]),
      .wd_i   (wdata),
      .rd_o   (ram_rd)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (RD_LAT == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 2'(RD_LAT - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         lo_q    <= 2'd0;
         size_q  <= SZ_W;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            lo_q   <= addr_i[1:0];
            size_q <= size_i;
            we_q   <= we_i;
            err_q  <= req_err;
         end
      end
   end

   assign rvalid_o = (state_q == RESP);
   assign busy_o   = (state_q != IDLE);
   assign err_o    = rvalid_o && err_q;
   assign rd_o     = (rvalid_o && !err_q && !we_q) ? load_extract(size_q, lo_q, ram_rd) : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_dmem_lsu;
   import dm_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, req1, we1, gnt1, rv1, err1, busy1;
   logic [2:0]  size1;
   logic [31:0] addr1, wd1, rd1;
   logic        rst3, req3, we3, gnt3, rv3, err3, busy3;
   logic [2:0]  size3;
   logic [31:0] addr3, wd3, rd3;

   int n_checks = 0;
   int n_pass   = 0;

   dmem_lsu #(.RD_LAT(1)) u1 (
      .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we1), .size_i(size1),
      .addr_i(addr1), .wd_i(wd1), .gnt_o(gnt1), .rvalid_o(rv1), .rd_o(rd1),
      .err_o(err1), .busy_o(busy1)
   );

   dmem_lsu #(.RD_LAT(3)) u3 (
      .clk_i(clk), .rst_i(rst3), .req_i(req3), .we_i(we3), .size_i(size3),
      .addr_i(addr3), .wd_i(wd3), .gnt_o(gnt3), .rvalid_o(rv3), .rd_o(rd3),
      .err_o(err3), .busy_o(busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic drive(input int sel, input logic req, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel == 1) begin
         req1 = req; we1 = we; size1 = sz; addr1 = a; wd1 = d;
      end else begin
         req3 = req; we3 = we; size3 = sz; addr3 = a; wd3 = d;
      end
   endtask

   // Issue one access from an idle DUT and check grant, latency, data and error.
   task automatic xact(input int sel, input string tag, input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
      int          lat;
      logic        v;
      logic [31:0] r;
      logic        e;
      @(negedge clk);
      drive(sel, 1'b1, we, sz, a, d);
      #1;
      check({tag, ".gnt"}, (sel == 1) ? gnt1 : gnt3, 1);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
      lat = 1;
      v   = (sel == 1) ? rv1 : rv3;
      while (!v && lat < 8) begin
         check({tag, ".quiet_rd"}, (sel == 1) ? {rd1[31:1], err1} | rd1 : rd3 | {31'h0, err3}, 0);
         @(negedge clk);
         lat++;
         v = (sel == 1) ? rv1 : rv3;
      end
      r = (sel == 1) ? rd1 : rd3;
      e = (sel == 1) ? err1 : err3;
      check({tag, ".lat"}, lat, (sel == 1) ? 1 : 3);
      check({tag, ".rd"}, r, exp_rd);
      check({tag, ".err"}, {31'h0, e}, {31'h0, exp_err});
      $display("[%0t] u%0d %-8s we=%b size=%b addr=%h wd=%h -> rd=%h err=%b lat=%0d",
               $time, sel, tag, we, sz, a, d, r, e, lat);
   endtask

   initial begin
      int seen_rv;
      rst1 = 1'b1; rst3 = 1'b1;
      drive(1, 1'b1, 1'b0, SZ_W, 32'h6600_0000, 32'h0);
      drive(3, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      check("rst.gnt",    {31'h0, gnt1},  0);
      check("rst.rvalid", {31'h0, rv1},   0);
      check("rst.busy",   {31'h0, busy1}, 0);
      check("rst.rd",     rd1, 0);
      check("rst.err",    {31'h0, err1},  0);
      drive(1, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
      rst1 = 1'b0; rst3 = 1'b0;

      // RD_LAT=1: lane stores, sign/zero-extended loads, error cases
      xact(1, "sw4",    1, SZ_W,  32'h6600_0004, 32'hFBFB_BFFF, 32'h0,         0);
      xact(1, "lw4",    0, SZ_W,  32'h6600_0004, 32'h0,         32'hFBFB_BFFF, 0);
      xact(1, "lb7",    0, SZ_B,  32'h6600_0007, 32'h0,         32'hFFFF_FFFB, 0);
      xact(1, "lbu7",   0, SZ_BU, 32'h6600_0007, 32'h0,         32'h0000_00FB, 0);
      xact(1, "lb4",    0, SZ_B,  32'h6600_0004, 32'h0,         32'hFFFF_FFFF, 0);
      xact(1, "lh4",    0, SZ_H,  32'h6600_0004, 32'h0,         32'hFFFF_BFFF, 0);
      xact(1, "lhu4",   0, SZ_HU, 32'h6600_0004, 32'h0,         32'h0000_BFFF, 0);
      xact(1, "sh6",    1, SZ_H,  32'h6600_0006, 32'hAAAA_1234, 32'h0,         0);
      xact(1, "lw4b",   0, SZ_W,  32'h6600_0004, 32'h0,         32'h1234_BFFF, 0);
      xact(1, "lh6",    0, SZ_H,  32'h6600_0006, 32'h0,         32'h0000_1234, 0);
      xact(1, "sb5",    1, SZ_B,  32'h6600_0005, 32'h0000_0077, 32'h0,         0);
      xact(1, "lw4c",   0, SZ_W,  32'h6600_0004, 32'h0,         32'h1234_77FF, 0);
      xact(1, "lw3",    0, SZ_W,  32'h6600_0003, 32'h0,         32'h0,         1);
      xact(1, "lh5",    0, SZ_H,  32'h6600_0005, 32'h0,         32'h0,         1);
      xact(1, "sw0",    1, SZ_W,  32'h6600_0000, 32'hA5A5_0000, 32'h0,         0);
      xact(1, "swffc",  1, SZ_W,  32'h6600_0FFC, 32'h1111_2222, 32'h0,         0);
      xact(1, "sw1000", 1, SZ_W,  32'h6600_1000, 32'hDEAD_BEEF, 32'h0,         1);
      xact(1, "lw0",    0, SZ_W,  32'h6600_0000, 32'h0,         32'hA5A5_0000, 0);
      xact(1, "lwffc",  0, SZ_W,  32'h6600_0FFC, 32'h0,         32'h1111_2222, 0);
      xact(1, "swlow",  1, SZ_W,  32'h65FF_FFFC, 32'h5555_5555, 32'h0,         1);
      xact(1, "bad011", 0, 3'b011, 32'h6600_0000, 32'h0,        32'h0,         1);
      xact(1, "sbu",    1, SZ_BU, 32'h6600_0000, 32'h0000_0033, 32'h0,         1);
      xact(1, "lw0b",   0, SZ_W,  32'h6600_0000, 32'h0,         32'hA5A5_0000, 0);

      // RD_LAT=3: back-to-back requests are granted every fourth cycle
      @(negedge clk);
      drive(3, 1'b1, 1'b0, SZ_W, 32'h6600_0000, 32'h0);
      for (int i = 0; i < 12; i++) begin
         #1;
         check($sformatf("pipe%0d.gnt", i),  {31'h0, gnt3},  {31'h0, (i % 4) == 0});
         check($sformatf("pipe%0d.rv", i),   {31'h0, rv3},   {31'h0, (i % 4) == 3});
         check($sformatf("pipe%0d.busy", i), {31'h0, busy3}, {31'h0, (i % 4) != 0});
         @(negedge clk);
      end
      drive(3, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
      $display("[%0t] u3 pipelined  12 cycles of continuous req", $time);

      // RD_LAT=3: reset during WAIT drops the response but keeps the store
      @(negedge clk);
      drive(3, 1'b1, 1'b1, SZ_W, 32'h6600_0010, 32'h0000_0009);
      #1;
      check("rstw.gnt", {31'h0, gnt3}, 1);
      @(negedge clk);
      drive(3, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
      check("rstw.busy_wait", {31'h0, busy3}, 1);
      rst3 = 1'b1;
      @(negedge clk);
      rst3 = 1'b0;
      check("rstw.busy_after", {31'h0, busy3}, 0);
      seen_rv = 0;
      for (int i = 0; i < 6; i++) begin
         if (rv3) seen_rv++;
         @(negedge clk);
      end
      check("rstw.no_rvalid", seen_rv, 0);
      $display("[%0t] u3 sw10     reset in WAIT, rvalid pulses seen=%0d", $time, seen_rv);
      xact(3, "lw10", 0, SZ_W, 32'h6600_0010, 32'h0, 32'h0000_0009, 0);
      xact(3, "lb11", 0, SZ_B, 32'h6600_0011, 32'h0, 32'h0000_0000, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
